// File: rtl/dice_pkg.sv
// Shared types for the dice roll decoder: color codes, controller states and
// per-frame result classification.
package dice_pkg;

  localparam logic [1:0] COLOR_NONE  = 2'b00;
  localparam logic [1:0] COLOR_RED   = 2'b01;
  localparam logic [1:0] COLOR_GREEN = 2'b10;
  localparam logic [1:0] COLOR_BLUE  = 2'b11;

  typedef enum logic [2:0] {
    SYNC,
    ARMED,
    CONFIRM,
    ISSUE,
    WAIT_REMOVE
  } dice_state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_COLOR,
    RES_WHITE
  } frame_res_t;

  // A detector pulse with both color and white asserted is ambiguous and counts as NONE.
  function automatic frame_res_t classify(input logic        cv,
                                          input logic        wd,
                                          input logic [1:0]  color,
                                          input logic [15:0] conf,
                                          input logic [15:0] min_conf);
    if (cv && !wd && (color != COLOR_NONE) && (conf >= min_conf)) return RES_COLOR;
    if (wd && !cv) return RES_WHITE;
    return RES_NONE;
  endfunction

endpackage

// File: rtl/dice_roll_decoder_if.sv
// Detector result stream, move handshake and status outputs of the dice roll decoder.
interface dice_roll_decoder_if;
  logic        frame_start;
  logic        color_valid;
  logic        white_detected;
  logic [1:0]  dominant_color;
  logic [15:0] color_confidence;
  logic        move_ready;
  logic        move_valid;
  logic [1:0]  move_steps;
  logic        armed;
  logic [7:0]  roll_count;
  logic        timeout_flag;

  modport master (
    output frame_start, color_valid, white_detected, dominant_color, color_confidence, move_ready,
    input  move_valid, move_steps, armed, roll_count, timeout_flag
  );

  modport slave (
    input  frame_start, color_valid, white_detected, dominant_color, color_confidence, move_ready,
    output move_valid, move_steps, armed, roll_count, timeout_flag
  );
endinterface

// File: rtl/dice_roll_decoder_streak.sv
// Saturating streak counter; hit_next says the increment applied now reaches THRESH.
module dice_streak_counter #(
  parameter int CNT_W  = 4,
  parameter int THRESH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // clr together with inc restarts the streak at 1 (new candidate observed)
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hit_next = (int'(cnt_q) + 1) >= THRESH;

endmodule

// File: rtl/dice_roll_decoder.sv
// Debounces detector results into one move request per dice placement.
// Optional forced re-arm after TIMEOUT_FRAMES in WAIT_REMOVE: define DICE_REMOVE_TIMEOUT_EN.
//
// state       | meaning
// SYNC        | after reset, waiting for an empty (white) ROI
// ARMED       | ready for a new roll, no candidate color
// CONFIRM     | candidate color seen, counting matching frames
// ISSUE       | move request pending until accepted
// WAIT_REMOVE | move sent, waiting for white frames (dice removed)
module dice_roll_decoder
  import dice_pkg::*;
#(
  parameter int          CONFIRM_FRAMES = 3,
  parameter int          REMOVE_FRAMES  = 2,
  parameter logic [15:0] MIN_CONFIDENCE = 16'd200,
  parameter int          CNT_W          = 4
`ifdef DICE_REMOVE_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT_FRAMES = 16'd300
`endif
) (
  input logic               clk,
  input logic               reset,
  dice_roll_decoder_if.slave bus
);

  dice_state_t state_q, state_d;
  logic [1:0]  cand_q, cand_d;
  logic [7:0]  roll_q;
  logic        fs_q, eval_q, fs_rise;
  frame_res_t  res;
  logic        c_inc, c_clr, c_hit_next;
  logic        w_inc, w_clr, w_hit_next;
  logic        roll_inc;
`ifdef DICE_REMOVE_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic        tmo_load, tmo_fire, timeout_q;
`endif

  assign fs_rise = bus.frame_start & ~fs_q;
  assign res     = classify(bus.color_valid, bus.white_detected, bus.dominant_color,
                            bus.color_confidence, MIN_CONFIDENCE);

  // Detector result lands one cycle after the frame boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_q   <= 1'b0;
      eval_q <= 1'b0;
    end else begin
      fs_q   <= bus.frame_start;
      eval_q <= fs_rise;
    end
  end

  dice_streak_counter #(.CNT_W(CNT_W), .THRESH(CONFIRM_FRAMES)) u_color_streak (
    .clk(clk), .reset(reset), .inc(c_inc), .clr(c_clr), .hit_next(c_hit_next)
  );

  dice_streak_counter #(.CNT_W(CNT_W), .THRESH(REMOVE_FRAMES)) u_white_streak (
    .clk(clk), .reset(reset), .inc(w_inc), .clr(w_clr), .hit_next(w_hit_next)
  );

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    c_inc    = 1'b0;
    c_clr    = 1'b0;
    w_inc    = 1'b0;
    w_clr    = 1'b0;
    roll_inc = 1'b0;
`ifdef DICE_REMOVE_TIMEOUT_EN
    tmo_load = 1'b0;
    tmo_fire = 1'b0;
`endif
    unique case (state_q)
      SYNC: begin
        if (eval_q && (res == RES_WHITE)) state_d = ARMED;
      end
      ARMED: begin
        if (eval_q && (res == RES_COLOR)) begin
          cand_d  = bus.dominant_color;
          c_clr   = 1'b1;
          c_inc   = 1'b1;
          state_d = (CONFIRM_FRAMES <= 1) ? ISSUE : CONFIRM;
        end
      end
      CONFIRM: begin
        if (eval_q) begin
          if ((res == RES_COLOR) && (bus.dominant_color == cand_q)) begin
            c_inc = 1'b1;
            if (c_hit_next) state_d = ISSUE;
          end else if (res == RES_COLOR) begin
            cand_d = bus.dominant_color;
            c_clr  = 1'b1;
            c_inc  = 1'b1;
          end else begin
            c_clr   = 1'b1;
            state_d = ARMED;
          end
        end
      end
      ISSUE: begin
        c_clr = 1'b1;
        if (bus.move_ready) begin
          roll_inc = 1'b1;
          w_clr    = 1'b1;
          state_d  = WAIT_REMOVE;
`ifdef DICE_REMOVE_TIMEOUT_EN
          tmo_load = 1'b1;
`endif
        end
      end
      WAIT_REMOVE: begin
        if (eval_q) begin
          if ((res == RES_WHITE) && w_hit_next) begin
            w_clr   = 1'b1;
            state_d = ARMED;
          end else if (res == RES_WHITE) begin
            w_inc = 1'b1;
          end else begin
            w_clr = 1'b1;
          end
        end
`ifdef DICE_REMOVE_TIMEOUT_EN
        if (!eval_q && fs_rise && (tmo_q == 16'd1)) begin
          w_clr    = 1'b1;
          tmo_fire = 1'b1;
          state_d  = ARMED;
        end
`endif
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SYNC;
      cand_q  <= COLOR_NONE;
      roll_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      if (roll_inc) roll_q <= roll_q + 8'd1;
    end
  end

`ifdef DICE_REMOVE_TIMEOUT_EN
  // Down-counter of remaining frame boundaries before forced re-arm
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_fire;
      if (tmo_load) begin
        tmo_q <= TIMEOUT_FRAMES;
      end else if ((state_q == WAIT_REMOVE) && fs_rise && (tmo_q != 16'd0)) begin
        tmo_q <= tmo_q - 16'd1;
      end
    end
  end

  assign bus.timeout_flag = timeout_q;
`else
  assign bus.timeout_flag = 1'b0;
`endif

  assign bus.move_valid = (state_q == ISSUE);
  assign bus.move_steps = (state_q == ISSUE) ? cand_q : COLOR_NONE;
  assign bus.armed      = (state_q == ARMED) || (state_q == CONFIRM);
  assign bus.roll_count = roll_q;

endmodule

// File: tb/tb_dice_roll_decoder.sv
// Self-checking bench for dice_roll_decoder: frame vector table, hand-written handshake/reset
// sequences and a randomized run against a run-length reference model.
`timescale 1ns/1ps
module tb_dice_roll_decoder;
  import dice_pkg::*;

  localparam int          CONFIRM  = 3;
  localparam int          REMOVE   = 2;
  localparam logic [15:0] MIN_CONF = 16'd200;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dice_roll_decoder_if bus();
  dice_roll_decoder dut (.clk(clk), .reset(reset), .bus(bus));

  typedef enum int {F_NONE, F_COLOR, F_WHITE, F_BOTH} fkind_t;
  typedef struct {
    fkind_t      kind;
    logic [1:0]  color;
    logic [15:0] conf;
    logic        exp_armed;
    logic [7:0]  exp_rolls;
    logic [1:0]  exp_steps;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int tmo_cnt = 0;
  logic [1:0] last_steps = 2'd0;

  always @(negedge clk) begin
    if (bus.move_valid && bus.move_ready) begin
      hs_cnt++;
      last_steps = bus.move_steps;
    end
    if (bus.timeout_flag) tmo_cnt++;
  end

  // Reference model: the game only cares about run lengths of classified frames
  int         m_phase;  // 0 unsynced, 1 ready for roll, 2 waiting for removal
  logic [1:0] m_color;
  int         m_run, m_wrun, m_moves;
  logic [7:0] m_rolls;
  logic [1:0] m_steps;

  function automatic void model_frame(fkind_t k, logic [1:0] c, logic [15:0] conf);
    bit is_col, is_white;
    is_col   = (k == F_COLOR) && (c != 2'd0) && (conf >= MIN_CONF);
    is_white = (k == F_WHITE);
    case (m_phase)
      0: if (is_white) m_phase = 1;
      1: begin
        if (is_col) begin
          if ((m_run > 0) && (c == m_color)) m_run++;
          else begin m_color = c; m_run = 1; end
          if (m_run >= CONFIRM) begin
            m_moves++; m_rolls++; m_steps = c;
            m_phase = 2; m_run = 0; m_wrun = 0;
          end
        end else m_run = 0;
      end
      default: begin
        if (is_white) begin
          m_wrun++;
          if (m_wrun >= REMOVE) begin m_phase = 1; m_wrun = 0; end
        end else m_wrun = 0;
      end
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic add(fkind_t k, logic [1:0] c, logic [15:0] conf, logic a, logic [7:0] r, logic [1:0] s);
    vec_t v;
    v.kind = k; v.color = c; v.conf = conf; v.exp_armed = a; v.exp_rolls = r; v.exp_steps = s;
    tbl.push_back(v);
  endtask

  task automatic drive_result(fkind_t k, logic [1:0] c, logic [15:0] conf);
    bus.color_valid      = (k == F_COLOR) || (k == F_BOTH);
    bus.white_detected   = (k == F_WHITE) || (k == F_BOTH);
    bus.dominant_color   = c;
    bus.color_confidence = conf;
  endtask

  task automatic clear_result();
    bus.color_valid = 1'b0; bus.white_detected = 1'b0;
    bus.dominant_color = 2'd0; bus.color_confidence = 16'd0;
  endtask

  task automatic send_frame(fkind_t k, logic [1:0] c, logic [15:0] conf);
    @(posedge clk); #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    drive_result(k, c, conf);
    @(posedge clk); #1 clear_result();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    fkind_t k;
    logic [1:0] c, prev;
    logic [15:0] conf;
    int r, held, hs_base, moves_before;

    bus.frame_start = 1'b0; bus.move_ready = 1'b1; clear_result();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst move_valid", bus.move_valid, 0);
    check("rst move_steps", bus.move_steps, 0);
    check("rst armed", bus.armed, 0);
    check("rst roll_count", bus.roll_count, 0);
    check("rst timeout_flag", bus.timeout_flag, 0);
    reset = 1'b0;

    add(F_COLOR, COLOR_RED, 500, 0, 0, 0); add(F_COLOR, COLOR_RED, 500, 0, 0, 0);
    add(F_COLOR, COLOR_RED, 500, 0, 0, 0); add(F_BOTH, COLOR_RED, 500, 0, 0, 0);
    add(F_WHITE, 0, 0, 1, 0, 0);
    add(F_COLOR, COLOR_GREEN, 500, 1, 0, 0); add(F_COLOR, COLOR_GREEN, 500, 1, 0, 0);
    add(F_COLOR, COLOR_GREEN, 500, 0, 1, 2);
    add(F_WHITE, 0, 0, 0, 1, 0); add(F_WHITE, 0, 0, 1, 1, 0);
    add(F_COLOR, COLOR_RED, 500, 1, 1, 0); add(F_COLOR, COLOR_RED, 500, 1, 1, 0);
    add(F_COLOR, COLOR_BLUE, 500, 1, 1, 0); add(F_COLOR, COLOR_BLUE, 500, 1, 1, 0);
    add(F_COLOR, COLOR_BLUE, 500, 0, 2, 3);
    add(F_WHITE, 0, 0, 0, 2, 0); add(F_WHITE, 0, 0, 1, 2, 0);
    add(F_COLOR, COLOR_RED, 500, 1, 2, 0); add(F_COLOR, COLOR_RED, 500, 1, 2, 0);
    add(F_WHITE, 0, 0, 1, 2, 0);
    for (int i = 0; i < 5; i++) add(F_COLOR, COLOR_BLUE, 150, 1, 2, 0);
    add(F_COLOR, COLOR_RED, 500, 1, 2, 0); add(F_COLOR, COLOR_RED, 500, 1, 2, 0);
    add(F_COLOR, COLOR_RED, 199, 1, 2, 0);
    add(F_COLOR, COLOR_RED, 200, 1, 2, 0); add(F_COLOR, COLOR_RED, 200, 1, 2, 0);
    add(F_COLOR, COLOR_RED, 200, 0, 3, 1);
    for (int i = 0; i < 4; i++) add(F_COLOR, COLOR_RED, 500, 0, 3, 0);
    add(F_WHITE, 0, 0, 0, 3, 0); add(F_COLOR, COLOR_RED, 500, 0, 3, 0);
    add(F_WHITE, 0, 0, 0, 3, 0); add(F_WHITE, 0, 0, 1, 3, 0);
    add(F_COLOR, COLOR_GREEN, 500, 1, 3, 0); add(F_COLOR, COLOR_NONE, 500, 1, 3, 0);
    add(F_COLOR, COLOR_GREEN, 500, 1, 3, 0); add(F_COLOR, COLOR_GREEN, 500, 1, 3, 0);
    add(F_COLOR, COLOR_GREEN, 500, 0, 4, 2);
    add(F_NONE, 0, 0, 0, 4, 0); add(F_WHITE, 0, 0, 0, 4, 0); add(F_WHITE, 0, 0, 1, 4, 0);

    foreach (tbl[i]) begin
      send_frame(tbl[i].kind, tbl[i].color, tbl[i].conf);
      check($sformatf("vec%0d armed", i), bus.armed, tbl[i].exp_armed);
      check($sformatf("vec%0d roll_count", i), bus.roll_count, tbl[i].exp_rolls);
      check($sformatf("vec%0d handshakes", i), hs_cnt, tbl[i].exp_rolls);
      if (tbl[i].exp_steps != 2'd0) check($sformatf("vec%0d move_steps", i), last_steps, tbl[i].exp_steps);
    end

    // color pulses without a frame boundary must not start a roll
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 drive_result(F_COLOR, COLOR_RED, 500);
      @(posedge clk); #1 clear_result();
      repeat (3) @(posedge clk);
    end
    #1;
    check("stray armed", bus.armed, 1);
    check("stray roll_count", bus.roll_count, 4);

    // held request: move_ready low for 10 cycles, frames during ISSUE ignored
    bus.move_ready = 1'b0;
    send_frame(F_COLOR, COLOR_RED, 500);
    send_frame(F_COLOR, COLOR_RED, 500);
    @(posedge clk); #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
    drive_result(F_COLOR, COLOR_RED, 500);
    check("latency eval cycle move_valid", bus.move_valid, 0);
    @(posedge clk); #1 clear_result();
    check("latency next cycle move_valid", bus.move_valid, 1);
    send_frame(F_WHITE, 0, 0);
    send_frame(F_WHITE, 0, 0);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.move_valid && (bus.move_steps == COLOR_RED)) held++;
    end
    check("held cycles", held, 10);
    check("held roll_count", bus.roll_count, 4);
    bus.move_ready = 1'b1;
    @(posedge clk); #1;
    check("release move_valid", bus.move_valid, 0);
    check("release roll_count", bus.roll_count, 5);
    check("release handshakes", hs_cnt, 5);
    check("release armed", bus.armed, 0);
    send_frame(F_WHITE, 0, 0);
    send_frame(F_WHITE, 0, 0);
    check("rearm armed", bus.armed, 1);

    // asynchronous reset while a request is pending
    bus.move_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(F_COLOR, COLOR_GREEN, 500);
    check("pre-reset move_valid", bus.move_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("async rst move_valid", bus.move_valid, 0);
    check("async rst move_steps", bus.move_steps, 0);
    check("async rst roll_count", bus.roll_count, 0);
    check("async rst armed", bus.armed, 0);
    @(posedge clk); #1 reset = 1'b0; bus.move_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(F_COLOR, COLOR_GREEN, 500);
    check("sync ignores color armed", bus.armed, 0);
    check("sync ignores color rolls", bus.roll_count, 0);
    send_frame(F_WHITE, 0, 0);
    check("sync white armed", bus.armed, 1);

    // randomized frames against the model
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    m_phase = 0; m_color = 0; m_run = 0; m_wrun = 0; m_moves = 0; m_rolls = 0; m_steps = 0;
    hs_base = hs_cnt;
    prev = COLOR_RED;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      k = (r < 2) ? F_WHITE : (r == 2) ? F_NONE : (r == 3) ? F_BOTH : F_COLOR;
      c = ($urandom_range(0, 1) == 1) ? prev : 2'($urandom_range(0, 3));
      prev = c;
      conf = 16'($urandom_range(150, 600));
      moves_before = m_moves;
      model_frame(k, c, conf);
      send_frame(k, c, conf);
      check($sformatf("rnd%0d armed", n), bus.armed, ((m_phase == 1) ? 1 : 0));
      check($sformatf("rnd%0d roll_count", n), bus.roll_count, m_rolls);
      check($sformatf("rnd%0d handshakes", n), hs_cnt - hs_base, m_moves);
      if (m_moves != moves_before) check($sformatf("rnd%0d move_steps", n), last_steps, m_steps);
    end

`ifdef DICE_REMOVE_TIMEOUT_EN
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    tmo_cnt = 0;
    send_frame(F_WHITE, 0, 0);
    for (int i = 0; i < 3; i++) send_frame(F_COLOR, COLOR_RED, 500);
    check("tmo move taken", bus.roll_count, 1);
    for (int i = 0; i < 299; i++) send_frame(F_COLOR, COLOR_RED, 500);
    check("tmo before armed", bus.armed, 0);
    check("tmo before pulses", tmo_cnt, 0);
    send_frame(F_COLOR, COLOR_RED, 500);
    check("tmo after armed", bus.armed, 1);
    check("tmo after pulses", tmo_cnt, 1);
`else
    check("no timeout pulses", tmo_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
